// File: rtl/tx_credit_sched_pkg.sv
// Shared types and credit arithmetic for the VC0 transmit scheduler.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package pcie_tx_sched_pkg;

    localparam logic [1:0] TLP_P   = 2'b00;
    localparam logic [1:0] TLP_NP  = 2'b01;
    localparam logic [1:0] TLP_CPL = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } sched_state_t;

    // Data credits are 4 DW each; round the payload up to whole credits.
    function automatic logic [10:0] data_credits(input logic [9:0] len);
        logic [10:0] sum;
        sum = {1'b0, len} + 11'd3;
        return sum >> 2;
    endfunction

    // Header need is always one credit; bit 8 advertises infinite credits.
    function automatic logic hdr_ok(input logic [8:0] ca);
        return ca[8] | (ca[7:0] != 8'd0);
    endfunction

    // Data need compared against the 12-bit count; bit 12 is infinite.
    function automatic logic dat_ok(input logic [12:0] ca, input logic [10:0] need);
        return ca[12] | (ca[11:0] >= {1'b0, need});
    endfunction

    // Reserved type 2'b11 never fits, so it is never granted.
    function automatic logic credit_ok(
        input logic [1:0]  typ,
        input logic [9:0]  len,
        input logic [8:0]  ph,
        input logic [12:0] pd,
        input logic [8:0]  nph,
        input logic [12:0] npd,
        input logic [8:0]  cplh,
        input logic [12:0] cpld
    );
        logic ok;
        case (typ)
            TLP_P:   ok = hdr_ok(ph) & dat_ok(pd, data_credits(len));
            TLP_NP:  ok = hdr_ok(nph) & dat_ok(npd, {10'd0, (len != 10'd0)});
            TLP_CPL: ok = hdr_ok(cplh) & dat_ok(cpld, data_credits(len));
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tx_credit_sched_rr_pick.sv
// Round-robin picker: first set request after ptr, searching upward modulo 4.
// Latency: purely combinational.
// Backpressure: none; vld is low when no request is set.
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic       vld
);

    logic [1:0] idx;

    // Walk ptr+1, ptr+2, ... and latch the first hit.
    always_comb begin
        gnt = 4'd0;
        vld = 1'b0;
        idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!vld && req[idx]) begin
                gnt[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_credit_sched.sv
// Credit-aware round-robin scheduler sharing the core VC0 transmit port among 4 TLP sources.
// Latency: req_i high in cycle n gives tx_req in cycle n+1; data path is combinational once granted.
// Backpressure: tx_rdy is forwarded only to the granted source; sources lacking credits are skipped.
module tx_credit_sched
    import pcie_tx_sched_pkg::*;
#(
    parameter int c_DATA_WIDTH = 16,
    parameter int N_REQ        = 4,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                          clk_125,
    input  logic                          rstn,
    input  logic [N_REQ-1:0]              req_i,
    input  logic [2*N_REQ-1:0]            req_type_i,
    input  logic [10*N_REQ-1:0]           req_len_i,
    input  logic [N_REQ*c_DATA_WIDTH-1:0] req_din_i,
    input  logic [N_REQ-1:0]              req_sop_i,
    input  logic [N_REQ-1:0]              req_eop_i,
    output logic [N_REQ-1:0]              rdy_o,
    output logic                          tx_req,
    output logic [c_DATA_WIDTH-1:0]       tx_data,
    output logic                          tx_st,
    output logic                          tx_end,
    input  logic                          tx_rdy,
    input  logic [8:0]                    tx_ca_ph,
    input  logic [12:0]                   tx_ca_pd,
    input  logic [8:0]                    tx_ca_nph,
    input  logic [12:0]                   tx_ca_npd,
    input  logic [8:0]                    tx_ca_cplh,
    input  logic [12:0]                   tx_ca_cpld,
    output logic [N_REQ-1:0]              grant_o,
    output logic                          proto_err_o
);

    sched_state_t state, state_nxt;
    logic [1:0]   rr_ptr;
    logic [1:0]   gidx;
    logic [3:0]   grant_r;
    logic [1:0]   gap_cnt;
    logic         req_lost;
    logic         err_nxt;
    logic [3:0]   eligible;
    logic [3:0]   pick_gnt;
    logic         pick_vld;
    logic [1:0]   pick_idx;
    logic         g_req, g_sop, g_eop;

    assign grant_o = grant_r;
    assign g_req   = req_i[gidx];
    assign g_sop   = req_sop_i[gidx];
    assign g_eop   = req_eop_i[gidx];

    // A source competes only if its pending TLP is covered by current credits.
    always_comb begin
        eligible = 4'd0;
        for (int i = 0; i < 4; i++) begin
            eligible[i] = req_i[i] & credit_ok(req_type_i[2*i +: 2], req_len_i[10*i +: 10],
                                               tx_ca_ph, tx_ca_pd, tx_ca_nph, tx_ca_npd,
                                               tx_ca_cplh, tx_ca_cpld);
        end
    end

    rr_pick u_rr_pick (
        .req (eligible),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .vld (pick_vld)
    );

    // One-hot winner to index.
    always_comb begin
        pick_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pick_gnt[i]) pick_idx = 2'(i);
        end
    end

    // Next state plus the combinational forward path of the granted source.
    always_comb begin
        state_nxt = state;
        tx_req    = 1'b0;
        rdy_o     = '0;
        tx_data   = '0;
        tx_st     = 1'b0;
        tx_end    = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) state_nxt = REQ;
            end
            REQ: begin
                tx_req      = 1'b1;
                rdy_o[gidx] = tx_rdy;
                tx_data     = req_din_i[{gidx, 4'b0000} +: 16];
                tx_st       = g_sop & tx_rdy;
                tx_end      = g_eop & tx_rdy;
                // A single-beat TLP accepted on the first ready goes straight to GAP.
                if (tx_rdy)      state_nxt = g_eop ? GAP : XFER;
                else if (!g_req) state_nxt = IDLE;
            end
            XFER: begin
                rdy_o[gidx] = tx_rdy;
                tx_data     = req_din_i[{gidx, 4'b0000} +: 16];
                tx_st       = g_sop & tx_rdy;
                tx_end      = g_eop & tx_rdy;
                if (tx_rdy && g_eop) state_nxt = GAP;
                // The opening sop was taken in REQ, so any sop here is a second one.
                err_nxt = (g_sop & tx_rdy) | (~g_req & ~req_lost);
            end
            GAP: begin
                if (gap_cnt == 2'(GAP_CYCLES - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Grant, pointer, gap counter and error pulse registers.
    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            rr_ptr      <= 2'd3;
            gidx        <= 2'd0;
            grant_r     <= 4'd0;
            gap_cnt     <= 2'd0;
            req_lost    <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            proto_err_o <= err_nxt;
            if (state == IDLE && pick_vld) begin
                grant_r <= pick_gnt;
                gidx    <= pick_idx;
                rr_ptr  <= pick_idx;
            end else if (state_nxt == IDLE || state_nxt == GAP) begin
                grant_r <= 4'd0;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 2'd1 : 2'd0;
            // Report a dropped request once per TLP, not every cycle it stays low.
            if (state == XFER && !g_req) req_lost <= 1'b1;
            else if (state != XFER)      req_lost <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_credit_sched.sv
// Randomized scoreboard bench for tx_credit_sched with a transaction-level round-robin model.
// Latency: stimulus updates 1 ns after each rising edge; outputs checked on the falling edge.
// Backpressure: tx_rdy is random, fixed or follows a pattern per phase.
module tb_tx_credit_sched;

    logic        clk_125 = 1'b0;
    logic        rstn;
    logic [3:0]  req_i;
    logic [7:0]  req_type_i;
    logic [39:0] req_len_i;
    logic [63:0] req_din_i;
    logic [3:0]  req_sop_i, req_eop_i;
    logic [3:0]  rdy_o;
    logic        tx_req;
    logic [15:0] tx_data;
    logic        tx_st, tx_end, tx_rdy;
    logic [8:0]  tx_ca_ph, tx_ca_nph, tx_ca_cplh;
    logic [12:0] tx_ca_pd, tx_ca_npd, tx_ca_cpld;
    logic [3:0]  grant_o;
    logic        proto_err_o;

    always #4 clk_125 = ~clk_125;

    tx_credit_sched #(.c_DATA_WIDTH(16), .N_REQ(4), .GAP_CYCLES(1)) dut (
        .clk_125(clk_125), .rstn(rstn), .req_i(req_i), .req_type_i(req_type_i),
        .req_len_i(req_len_i), .req_din_i(req_din_i), .req_sop_i(req_sop_i),
        .req_eop_i(req_eop_i), .rdy_o(rdy_o), .tx_req(tx_req), .tx_data(tx_data),
        .tx_st(tx_st), .tx_end(tx_end), .tx_rdy(tx_rdy), .tx_ca_ph(tx_ca_ph),
        .tx_ca_pd(tx_ca_pd), .tx_ca_nph(tx_ca_nph), .tx_ca_npd(tx_ca_npd),
        .tx_ca_cplh(tx_ca_cplh), .tx_ca_cpld(tx_ca_cpld), .grant_o(grant_o),
        .proto_err_o(proto_err_o)
    );

    typedef struct { int typ; int len; int nb; int id; int xsop; } pkt_t;
    typedef struct { int src; logic [15:0] dat; logic sop; logic eop; } beat_t;

    pkt_t       src_q[4][$];
    int         cur_beat[4];
    beat_t      exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         err_pulses = 0;
    bit         mon_en = 1'b0;
    int         rdy_mode = 1;
    int         rdy_pat[$];
    int         model_ptr = 3;
    int         next_id = 0;
    logic [3:0] acc = 4'd0;
    logic [3:0] prev_grant = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] din_of(input int s, input int id, input int b);
        return {2'(s), 6'(id), 8'(b)};
    endfunction

    function automatic bit have(input logic inf, input int avail, input int need);
        return inf || (avail >= need);
    endfunction

    // Credit rule from the TLP's point of view: one header, ceil(len/4) data credits.
    function automatic bit fits(input pkt_t p);
        int dc;
        dc = (p.len + 3) / 4;
        case (p.typ)
            0: return have(tx_ca_ph[8], int'(tx_ca_ph[7:0]), 1) &&
                      have(tx_ca_pd[12], int'(tx_ca_pd[11:0]), dc);
            1: return have(tx_ca_nph[8], int'(tx_ca_nph[7:0]), 1) &&
                      have(tx_ca_npd[12], int'(tx_ca_npd[11:0]), (p.len != 0) ? 1 : 0);
            2: return have(tx_ca_cplh[8], int'(tx_ca_cplh[7:0]), 1) &&
                      have(tx_ca_cpld[12], int'(tx_ca_cpld[11:0]), dc);
            default: return 1'b0;
        endcase
    endfunction

    task automatic add_pkt(input int s, input int typ, input int len, input int nb, input int xsop);
        pkt_t p;
        p.typ = typ; p.len = len; p.nb = nb; p.id = next_id % 64; p.xsop = xsop;
        next_id++;
        src_q[s].push_back(p);
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0) begin
                req_i[i]            = 1'b1;
                req_type_i[2*i +: 2] = 2'(src_q[i][0].typ);
                req_len_i[10*i +: 10] = 10'(src_q[i][0].len);
                req_din_i[16*i +: 16] = din_of(i, src_q[i][0].id, cur_beat[i]);
                req_sop_i[i]        = (cur_beat[i] == 0) || (cur_beat[i] == src_q[i][0].xsop);
                req_eop_i[i]        = (cur_beat[i] == src_q[i][0].nb - 1);
            end else begin
                req_i[i]            = 1'b0;
                req_type_i[2*i +: 2] = 2'b00;
                req_len_i[10*i +: 10] = 10'd0;
                req_din_i[16*i +: 16] = 16'd0;
                req_sop_i[i]        = 1'b0;
                req_eop_i[i]        = 1'b0;
            end
        end
        case (rdy_mode)
            0: tx_rdy = ($urandom_range(0, 3) != 0);
            1: tx_rdy = 1'b1;
            2: tx_rdy = 1'b0;
            default: tx_rdy = (rdy_pat.size() > 0) ? (rdy_pat.pop_front() != 0) : 1'b1;
        endcase
    endtask

    task automatic advance();
        for (int i = 0; i < 4; i++) begin
            if (acc[i] && src_q[i].size() > 0) begin
                cur_beat[i]++;
                if (cur_beat[i] == src_q[i][0].nb) begin
                    void'(src_q[i].pop_front());
                    cur_beat[i] = 0;
                end
            end
        end
    endtask

    // One cycle: update sources after the edge, then land just past the falling edge.
    task automatic step();
        @(posedge clk_125);
        #1;
        advance();
        drive();
        @(negedge clk_125);
        acc = rdy_o;
        #1;
    endtask

    // Transaction-level model: serve head TLPs that fit, round-robin from the last winner.
    task automatic plan();
        int   h[4];
        int   w;
        int   i;
        pkt_t p;
        for (int k = 0; k < 4; k++) h[k] = 0;
        w = 0;
        while (w >= 0) begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                i = (model_ptr + k) % 4;
                if (w < 0 && h[i] < src_q[i].size()) begin
                    if (fits(src_q[i][h[i]])) w = i;
                end
            end
            if (w >= 0) begin
                p = src_q[w][h[w]];
                h[w]++;
                model_ptr = w;
                for (int b = 0; b < p.nb; b++)
                    exp_q.push_back('{src: w, dat: din_of(w, p.id, b),
                                      sop: (b == 0) || (b == p.xsop), eop: (b == p.nb - 1)});
            end
        end
    endtask

    task automatic drain(input int exp_err, input bit drop);
        int e0;
        int n;
        e0 = err_pulses;
        n = 0;
        while ((exp_q.size() != 0 || grant_o != 4'd0) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) chk("drain_timeout_beats_left", exp_q.size(), 0);
        repeat (4) begin
            step();
            chk("idle_no_grant", grant_o, 0);
        end
        chk("proto_err_pulses", err_pulses - e0, exp_err);
        if (drop) begin
            for (int i = 0; i < 4; i++) begin
                src_q[i].delete();
                cur_beat[i] = 0;
            end
            step();
        end
    endtask

    task automatic set_inf();
        tx_ca_ph = 9'h100; tx_ca_nph = 9'h100; tx_ca_cplh = 9'h100;
        tx_ca_pd = 13'h1000; tx_ca_npd = 13'h1000; tx_ca_cpld = 13'h1000;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_grant"}, grant_o, 0);
        chk({tag, "_rdy"}, rdy_o, 0);
        chk({tag, "_req_st_end_err"}, {tx_req, tx_st, tx_end, proto_err_o}, 0);
        chk({tag, "_data"}, tx_data, 0);
    endtask

    // Monitor: compare each new grant and each accepted beat with the scoreboard head.
    always @(negedge clk_125) begin
        if (mon_en && rstn) begin
            if (prev_grant == 4'd0 && grant_o != 4'd0) begin
                if (exp_q.size() == 0) chk("unexpected_grant", grant_o, 0);
                else                   chk("grant_onehot", grant_o, 32'(1) << exp_q[0].src);
            end
            if (rdy_o != 4'd0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", rdy_o, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_rdy_o", rdy_o, 32'(1) << e.src);
                    chk("beat_data", tx_data, e.dat);
                    chk("beat_st_end", {tx_st, tx_end}, {e.sop, e.eop});
                end
            end else if (grant_o != 4'd0 && exp_q.size() > 0) begin
                chk("stall_rdy_st_end", {tx_rdy, tx_st, tx_end}, 0);
                chk("stall_data_hold", tx_data, req_din_i[16*exp_q[0].src +: 16]);
            end
            if (proto_err_o) err_pulses++;
        end
        prev_grant = grant_o;
    end

    initial begin
        int n;
        rstn = 1'b0;
        req_i = '0; req_type_i = '0; req_len_i = '0; req_din_i = '0;
        req_sop_i = '0; req_eop_i = '0; tx_rdy = 1'b0;
        tx_ca_ph = '0; tx_ca_pd = '0; tx_ca_nph = '0; tx_ca_npd = '0;
        tx_ca_cplh = '0; tx_ca_cpld = '0;
        for (int i = 0; i < 4; i++) cur_beat[i] = 0;
        #18;
        chk_outputs_zero("reset");
        @(negedge clk_125);
        rstn = 1'b1;
        step();
        mon_en = 1'b1;

        // Single posted TLP on source 1 with just enough credits.
        tx_ca_ph = 9'd1; tx_ca_pd = 13'd2;
        rdy_mode = 1;
        add_pkt(1, 0, 8, 3, -1);
        plan();
        step();
        chk("latency_cycle_n_req", tx_req, 0);
        step();
        chk("latency_cycle_n1_req", tx_req, 1);
        chk("latency_grant", grant_o, 4'b0010);
        n = 0;
        while (!tx_end && n < 20) begin step(); n++; end
        chk("single_tx_end_seen", tx_end, 1);
        step();
        chk("gap_grant_and_req", {grant_o, tx_req}, 0);
        drain(0, 1);

        // Four completion sources, three TLPs each, infinite credits.
        set_inf();
        rdy_mode = 0;
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < 4; s++)
                add_pkt(s, 2, $urandom_range(0, 32), $urandom_range(1, 4), -1);
        plan();
        drain(0, 1);

        // Starved posted source must not block a completion; it goes once pd covers it.
        tx_ca_ph = 9'd1; tx_ca_pd = 13'd15; tx_ca_cplh = 9'd1; tx_ca_cpld = 13'd1;
        tx_ca_nph = 9'd0; tx_ca_npd = 13'd0;
        add_pkt(0, 0, 64, 2, -1);
        add_pkt(2, 2, 4, 2, -1);
        plan();
        drain(0, 0);
        tx_ca_pd = 13'd16;
        plan();
        drain(0, 1);

        // tx_rdy pattern 1,0,0,1 inside a transfer.
        set_inf();
        rdy_mode = 3;
        rdy_pat = '{0, 1, 1, 0, 0, 1, 0, 1};
        add_pkt(2, 2, 12, 4, -1);
        plan();
        drain(0, 1);

        // Second sop before eop: forwarded, one error pulse.
        rdy_mode = 0;
        add_pkt(1, 1, 0, 4, 2);
        plan();
        drain(1, 1);

        // Source 3 abandons its request while still waiting for tx_rdy.
        mon_en = 1'b0;
        rdy_mode = 2;
        add_pkt(3, 2, 0, 2, -1);
        n = 0;
        while (grant_o != 4'b1000 && n < 10) begin step(); n++; end
        chk("abandon_grant", grant_o, 4'b1000);
        chk("abandon_req_before_drop", {tx_req, tx_st}, 2'b10);
        src_q[3].delete();
        cur_beat[3] = 0;
        step();
        chk("abandon_drop_cycle", {tx_st, proto_err_o}, 0);
        step();
        chk("abandon_next_cycle", {grant_o, tx_req, tx_st, proto_err_o}, 0);
        model_ptr = 3;
        step();
        mon_en = 1'b1;

        // Randomized credits, types, lengths and backpressure.
        for (int ph = 0; ph < 12; ph++) begin
            tx_ca_ph   = {($urandom_range(0, 1) == 1), 8'($urandom_range(0, 2))};
            tx_ca_nph  = {($urandom_range(0, 1) == 1), 8'($urandom_range(0, 2))};
            tx_ca_cplh = {($urandom_range(0, 1) == 1), 8'($urandom_range(0, 2))};
            tx_ca_pd   = {($urandom_range(0, 2) == 0), 12'($urandom_range(0, 12))};
            tx_ca_npd  = {($urandom_range(0, 2) == 0), 12'($urandom_range(0, 2))};
            tx_ca_cpld = {($urandom_range(0, 2) == 0), 12'($urandom_range(0, 12))};
            rdy_mode = 0;
            for (int s = 0; s < 4; s++)
                repeat ($urandom_range(0, 3))
                    add_pkt(s, ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2),
                            $urandom_range(0, 40), $urandom_range(1, 4), -1);
            plan();
            drain(0, 1);
        end

        // Reset in the middle of a transfer, then restart from pointer 3.
        mon_en = 1'b0;
        set_inf();
        rdy_mode = 1;
        add_pkt(1, 2, 0, 6, -1);
        n = 0;
        while (grant_o == 4'd0 && n < 10) begin step(); n++; end
        step();
        step();
        chk("pre_reset_in_transfer", grant_o, 4'b0010);
        rstn = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        for (int i = 0; i < 4; i++) begin
            src_q[i].delete();
            cur_beat[i] = 0;
        end
        exp_q.delete();
        acc = 4'd0;
        step();
        step();
        rstn = 1'b1;
        model_ptr = 3;
        step();
        mon_en = 1'b1;
        rdy_mode = 0;
        for (int s = 3; s >= 0; s--) add_pkt(s, 2, 8, 2, -1);
        plan();
        chk("model_first_after_reset", exp_q[0].src, 0);
        drain(0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_credit_sched.md
Name: tx_credit_sched

Overview:
- Credit-aware round-robin scheduler that shares the PCIe core VC0 transmit port (tx_req/tx_rdy/tx_st/tx_end/tx_data, 16-bit) among N_REQ TLP sources (wishbone completer, SFIF DMA, UR generator, spare).
- Grants a source only when the core's advertised credits (tx_ca_*) cover that source's pending TLP, so a credit-starved source never blocks the others.
- Sits between the TLP sources and pcie_top, and replaces the plain transmit arbiter in the top level.

Parameters:
- c_DATA_WIDTH, 16, transmit data width; only 16 supported.
- N_REQ, 4, number of requesters; fixed at 4 for packed-port widths.
- GAP_CYCLES, 1, idle cycles after tx_end before the next grant (1..3).

Ports:
- clk_125 in 1 : 125 MHz clock.
- rstn in 1 : reset.
- req_i in 4 : per-source TLP pending; held high until its eop is accepted.
- req_type_i in 8 : 2 bits per source (bits [2i+1:2i]); 00 posted, 01 non-posted, 10 completion, 11 reserved (never granted).
- req_len_i in 40 : 10 bits per source; payload length in DW; 0 = header only.
- req_din_i in 64 : 16 bits per source; TLP data.
- req_sop_i in 4 : per-source start of TLP.
- req_eop_i in 4 : per-source end of TLP.
- rdy_o out 4 : per-source tx_rdy, forwarded to the granted source only.
- tx_req out 1 : request to the core.
- tx_data out 16 : data to the core.
- tx_st out 1 : start of TLP to the core.
- tx_end out 1 : end of TLP to the core.
- tx_rdy in 1 : core ready.
- tx_ca_ph in 9 : posted header credits; bit 8 = infinite.
- tx_ca_pd in 13 : posted data credits; bit 12 = infinite.
- tx_ca_nph in 9 : non-posted header credits.
- tx_ca_npd in 13 : non-posted data credits.
- tx_ca_cplh in 9 : completion header credits.
- tx_ca_cpld in 13 : completion data credits.
- grant_o out 4 : registered one-hot grant; 0 when idle.
- proto_err_o out 1 : one-cycle pulse on a framing violation.

Behaviour:
- Reset (rstn, asynchronous, active-low; clock clk_125):
  - State IDLE, rr_ptr = 3.
  - grant_o, rdy_o, tx_req, tx_st, tx_end, tx_data and proto_err_o all 0.
- Credit need per source, with dc = ceil(len/4) = (len+3)>>2 computed at 11 bits:
  - posted: ph ≥ 1 and pd ≥ dc.
  - non-posted: nph ≥ 1 and npd ≥ (len≠0 ? 1 : 0).
  - completion: cplh ≥ 1 and cpld ≥ dc.
  - Each comparison is satisfied if the infinite bit is set; otherwise compare the lower 8 or 12 bits unsigned.
  - eligible[i] = req_i[i] & credit_ok[i] & (type≠11).
- IDLE:
  - If eligible≠0, pick the first eligible index searching rr_ptr+1, rr_ptr+2, ... modulo 4.
  - Register the one-hot grant_o, set rr_ptr = winner, go to REQ. Latency: req_i high at cycle n gives tx_req=1 at cycle n+1.
  - Credits are sampled only in IDLE.
- REQ:
  - tx_req = 1.
  - If req_i[g] drops before tx_rdy: abandon and go to IDLE next cycle. grant_o clears, rr_ptr is kept.
  - On tx_rdy=1: go to XFER. tx_req is 0 from the next cycle.
- Datapath (combinational), in REQ and XFER:
  - rdy_o[g] = tx_rdy; all other rdy_o bits are 0.
  - tx_data = req_din_i[g].
  - tx_st = req_sop_i[g] & tx_rdy.
  - tx_end = req_eop_i[g] & tx_rdy.
  - In all other states these outputs are 0.
- XFER:
  - A cycle with tx_rdy=0 is a stall; hold the state.
  - tx_end with tx_rdy=1 moves to GAP (a single-beat TLP, sop and eop in the same cycle, is legal).
  - A second sop before eop pulses proto_err_o and is still forwarded.
  - req_i[g] dropping in XFER pulses proto_err_o; the state stays until eop.
- GAP:
  - Count GAP_CYCLES with grant_o=0, then go to IDLE.
  - Requests arriving during GAP are evaluated in IDLE.
- Simultaneous events: multiple eligible sources resolve by round-robin only; there is no fixed priority.
- Credit changes during XFER are ignored; the core applies nullify/recheck itself.
- Mid-packet reset returns to the reset state immediately; the core is reset by the same rstn.

Decomposition:
- Package pcie_tx_sched_pkg holds:
  - type codes TLP_P=2'b00, TLP_NP=2'b01, TLP_CPL=2'b10;
  - state encoding IDLE/REQ/XFER/GAP;
  - function data_credits(len) and function credit_ok(type, len, ca_*).
- Sub-module rr_pick: 4-bit request vector plus 2-bit pointer in, one-hot grant plus a valid flag out; purely combinational.

Test Plan:
- Single posted request, len=8 on source 1, ph=1, pd=2: tx_req at cycle +1; forward after tx_rdy; grant_o=0010 until tx_end; 1 GAP cycle; back to IDLE.
- All 4 requesting completions with infinite credits, 3 TLPs each: grant order 0,1,2,3,0,1,2,3,...; no source is granted twice in a row.
- Source 0 posted len=64 with pd=15, source 2 completion with cplh=1: source 2 is granted first. After pd rises to 16, source 0 is granted.
- tx_rdy toggling 1,0,0,1 during XFER: tx_data holds, tx_st/tx_end fire only with tx_rdy=1, state stays XFER.
- Source 3 drops req_i in REQ before tx_rdy: tx_req goes 0 next cycle, no tx_st is seen, proto_err_o=0. Second sop before eop gives one proto_err_o pulse.
- rstn asserted mid-XFER: all outputs 0 asynchronously; after release, a new request is granted from pointer 3 (source 0 first).
